// File: rtl/systolic_array_ws_tile_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic tile.
package strait_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // The partial-sum width must hold ROWS full-width products without overflow.
  function automatic int psum_width(input int weight_width, input int act_width, input int rows);
    return weight_width + act_width + $clog2(rows);
  endfunction

  // Accept-to-result latency in cycles: ROWS + COLS.
  function automatic int tile_latency(input int rows, input int cols);
    return rows + cols;
  endfunction

  localparam int LATENCY = tile_latency(8, 8);

endpackage

// File: rtl/systolic_array_ws_tile_if.sv
// Weight, activation and result handshake bundle for the systolic tile.
interface systolic_array_ws_tile_if
  import strait_array_pkg::*;
#(
  parameter int ROWS              = 8,
  parameter int COLS              = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, ROWS)
);

  logic                              w_valid;
  logic                              w_ready;
  logic [COLS*WEIGHT_WIDTH-1:0]      w_row;
  logic                              act_valid;
  logic                              act_ready;
  logic [ROWS*ACTIVATION_WIDTH-1:0]  act_vec;
  logic                              out_valid;
  logic                              out_ready;
  logic [COLS*PARTIAL_SUM_WIDTH-1:0] out_vec;

  modport master (
    output w_valid, w_row, act_valid, act_vec, out_ready,
    input  w_ready, act_ready, out_valid, out_vec
  );

  modport slave (
    input  w_valid, w_row, act_valid, act_vec, out_ready,
    output w_ready, act_ready, out_valid, out_vec
  );

endinterface

// File: rtl/systolic_array_ws_tile_pe.sv
// Weight-stationary signed MAC processing element (strait_pe_ws).
// Column bypass mux is only built when STRAIT_COL_BYPASS_EN is defined.
module strait_pe_ws #(
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = 19
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                w_load,
  input  logic signed [WEIGHT_WIDTH-1:0]      w_in,
  output logic signed [WEIGHT_WIDTH-1:0]      w_out,
  input  logic signed [ACTIVATION_WIDTH-1:0]  a_in,
  output logic signed [ACTIVATION_WIDTH-1:0]  a_out,
  input  logic signed [PARTIAL_SUM_WIDTH-1:0] psum_in,
  output logic signed [PARTIAL_SUM_WIDTH-1:0] psum_out,
  input  logic                                bypass
);

  logic signed [WEIGHT_WIDTH-1:0]                  w_q;
  logic signed [ACTIVATION_WIDTH-1:0]              a_q;
  logic signed [PARTIAL_SUM_WIDTH-1:0]             psum_q;
  logic signed [WEIGHT_WIDTH+ACTIVATION_WIDTH-1:0] prod;
  logic signed [PARTIAL_SUM_WIDTH-1:0]             psum_next;

  assign prod = a_in * w_q;

`ifdef STRAIT_COL_BYPASS_EN
  assign psum_next = bypass ? psum_in : psum_in + PARTIAL_SUM_WIDTH'(prod);
`else
  logic unused_bypass;
  assign unused_bypass = bypass;
  assign psum_next     = psum_in + PARTIAL_SUM_WIDTH'(prod);
`endif

  // Weights shift independently of stall: loading only happens with the array empty.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (rst) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      if (w_load) w_q <= w_in;
      if (en) begin
        a_q    <= a_in;
        psum_q <= psum_next;
      end
    end
  end

  assign w_out    = w_q;
  assign a_out    = a_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/systolic_array_ws_tile.sv
// Weight-stationary ROWS x COLS systolic tile with weight-load FSM, skew/deskew and stall.
// Define STRAIT_COL_BYPASS_EN to honour col_disable; otherwise the port is ignored.
module systolic_array_ws_tile
  import strait_array_pkg::*;
#(
  parameter int ROWS              = 8,
  parameter int COLS              = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, ROWS)
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_array_ws_tile_if.slave bus,
  input  logic [COLS-1:0]         col_disable,
  output logic                    busy
);

  localparam int WW         = WEIGHT_WIDTH;
  localparam int AW         = ACTIVATION_WIDTH;
  localparam int PSW        = PARTIAL_SUM_WIDTH;
  localparam int PIPE_DEPTH = tile_latency(ROWS, COLS);
  localparam int CNT_W      = $clog2(PIPE_DEPTH + 1);
  localparam int BEAT_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]      inflight_q;
  logic [PIPE_DEPTH-1:0] vld_q;
  logic                  stall;
  logic                  w_fire;
  logic                  act_fire;
  logic                  out_fire;
  logic [COLS-1:0]       bypass_mask;

  // Handshakes and backpressure
  assign stall         = bus.out_valid && !bus.out_ready;
  assign bus.w_ready   = !rst && (state_q == S_IDLE || state_q == S_LOAD);
  assign bus.act_ready = !rst && (state_q == S_RUN) && !stall;
  assign bus.out_valid = vld_q[PIPE_DEPTH-1];
  assign w_fire        = bus.w_valid && bus.w_ready;
  assign act_fire      = bus.act_valid && bus.act_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign busy          = (state_q != S_IDLE) || (inflight_q != '0);

  always_comb begin
    // NOTE: defaults first so every path assigns the next-state values and no latch is inferred.
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (w_fire) begin
          if (beat_q == BEAT_W'(ROWS - 1)) begin
            state_d = S_RUN;
            beat_d  = '0;
          end else begin
            state_d = S_LOAD;
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      S_RUN:   if (bus.w_valid) state_d = S_DRAIN;
      S_DRAIN: if (inflight_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The valid pipe mirrors the data wavefront so bubbles stay aligned with their slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (act_fire && !out_fire)      inflight_q <= inflight_q + 1'b1;
      else if (!act_fire && out_fire) inflight_q <= inflight_q - 1'b1;
      if (!stall) vld_q <= {vld_q[PIPE_DEPTH-2:0], act_fire};
    end
  end

`ifdef STRAIT_COL_BYPASS_EN
  // Mask is frozen once the tile leaves LOAD so a running batch sees one configuration.
  logic [COLS-1:0] col_dis_q;
  always_ff @(posedge clk) begin
    if (rst)                                       col_dis_q <= '0;
    else if (state_q == S_IDLE || state_q == S_LOAD) col_dis_q <= col_disable;
  end
  assign bypass_mask = col_dis_q;
`else
  logic unused_col_disable;
  assign unused_col_disable = ^col_disable;
  assign bypass_mask        = '0;
`endif

  logic signed [AW-1:0]  act_link [ROWS][COLS+1];
  logic signed [WW-1:0]  w_link   [ROWS+1][COLS];
  logic signed [PSW-1:0] ps_link  [ROWS+1][COLS];

  // Input skew: row i sits behind i+1 registers (one capture stage plus i delay stages).
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    logic signed [AW-1:0] sr [0:i];
    always_ff @(posedge clk) begin
      // NOTE: skew and deskew arrays are reset element-wise; rst must discard in-flight data.
      if (rst) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else if (!stall) begin
        sr[0] <= act_fire ? bus.act_vec[i*AW +: AW] : '0;
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end
    assign act_link[i][0] = sr[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_top_edge
    assign w_link[0][j]  = bus.w_row[j*WW +: WW];
    assign ps_link[0][j] = '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      strait_pe_ws #(
        .WEIGHT_WIDTH      (WW),
        .ACTIVATION_WIDTH  (AW),
        .PARTIAL_SUM_WIDTH (PSW)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (!stall),
        .w_load   (w_fire),
        .w_in     (w_link[i][j]),
        .w_out    (w_link[i+1][j]),
        .a_in     (act_link[i][j]),
        .a_out    (act_link[i][j+1]),
        .psum_in  (ps_link[i][j]),
        .psum_out (ps_link[i+1][j]),
        .bypass   (bypass_mask[j])
      );
    end
  end

  // Activations leaving the east edge and weights leaving the bottom edge go nowhere.
  logic unused_east  [ROWS];
  logic unused_south [COLS];
  for (genvar i = 0; i < ROWS; i++) begin : g_east
    assign unused_east[i] = ^act_link[i][COLS];
  end

  // Output deskew: column j waits COLS-1-j cycles so all columns of a vector line up.
  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int D = COLS - 1 - j;
    logic signed [PSW-1:0] col_out;
    assign unused_south[j] = ^w_link[ROWS][j];
    if (D == 0) begin : g_direct
      assign col_out = ps_link[ROWS][j];
    end else begin : g_dly
      logic signed [PSW-1:0] dq [0:D-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dq[k] <= '0;
        end else if (!stall) begin
          dq[0] <= ps_link[ROWS][j];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign col_out = dq[D-1];
    end
    assign bus.out_vec[j*PSW +: PSW] = col_out;
  end

endmodule

// File: tb/tb_systolic_array_ws_tile.sv
// Scoreboard bench for systolic_array_ws_tile: directed vectors, decoupled output monitor.
module tb_systolic_array_ws_tile;
  import strait_array_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int WW   = 8;
  localparam int AW   = 8;
  localparam int PSW  = psum_width(WW, AW, ROWS);
  localparam int OUTW = COLS * PSW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] col_disable = '0;
  logic            busy;

  always #5 clk = ~clk;

  systolic_array_ws_tile_if #(
    .ROWS(ROWS), .COLS(COLS), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AW), .PARTIAL_SUM_WIDTH(PSW)
  ) bus ();

  systolic_array_ws_tile #(
    .ROWS(ROWS), .COLS(COLS), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AW), .PARTIAL_SUM_WIDTH(PSW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .col_disable (col_disable),
    .busy        (busy)
  );

  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   n_out    = 0;
  int                   cyc      = 0;
  int                   acc_cyc  = 0;
  bit                   rand_ready = 1'b0;
  logic [OUTW-1:0]      exp_q [$];
  logic signed [WW-1:0] wm [ROWS][COLS];
  logic [COLS-1:0]      exp_mask = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: out[j] = sum_i act[i]*W[i][j], zero for a bypassed column.
  function automatic logic [OUTW-1:0] golden(input logic [ROWS*AW-1:0] a);
    logic [OUTW-1:0] r;
    int s;
    r = '0;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int i = 0; i < ROWS; i++) s += int'($signed(a[i*AW +: AW])) * int'(wm[i][j]);
      if (exp_mask[j]) s = 0;
      r[j*PSW +: PSW] = s[PSW-1:0];
    end
    return r;
  endfunction

  // Monitor: pops on each output handshake and checks hold behaviour while stalled.
  logic            prev_stall = 1'b0;
  logic [OUTW-1:0] prev_vec;
  logic [OUTW-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", bus.out_valid, 1);
        check("stall_vec_hold", bus.out_vec, prev_vec);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_vec", bus.out_vec, mon_exp);
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_vec   = bus.out_vec;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_w(input logic [COLS*WW-1:0] row, output int waits);
    bit hs = 1'b0;
    waits = 0;
    bus.w_valid = 1'b1;
    bus.w_row   = row;
    while (!hs && waits < 200) begin
      @(negedge clk);
      hs = bus.w_ready;
      @(posedge clk);
      #1;
      if (!hs) waits++;
    end
    if (!hs) check("w_handshake_timeout", hs, 1);
  endtask

  // Beat k is row ROWS-1-k because beats shift downward through the array.
  task automatic load_weights(output int first_waits);
    logic [COLS*WW-1:0] row;
    int w;
    first_waits = 0;
    for (int k = 0; k < ROWS; k++) begin
      for (int j = 0; j < COLS; j++) row[j*WW +: WW] = wm[ROWS-1-k][j];
      send_w(row, w);
      if (k == 0) first_waits = w;
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic send_act(input logic [ROWS*AW-1:0] vec, input logic [OUTW-1:0] exp);
    bit hs = 1'b0;
    int n = 0;
    bus.act_valid = 1'b1;
    bus.act_vec   = vec;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = bus.act_ready;
      if (hs) begin
        exp_q.push_back(exp);
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("act_handshake_timeout", hs, 1);
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (n_out < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("outputs_delivered", n_out, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS*AW-1:0] vec;
    logic [OUTW-1:0]    exp;
    int                 fw;
    int                 lat;
    int                 base;

    bus.w_valid   = 1'b0;
    bus.w_row     = '0;
    bus.act_valid = 1'b0;
    bus.act_vec   = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_act_ready", bus.act_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_vec", bus.out_vec, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_w_ready", bus.w_ready, 1);
    @(posedge clk);
    #1;

    // Identity weights, act = 1..8, exact latency
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = (i == j) ? 8'sd1 : 8'sd0;
    load_weights(fw);
    exp = '0;
    for (int i = 0; i < ROWS; i++) begin
      vec[i*AW +: AW] = AW'(i + 1);
      exp[i*PSW +: PSW] = PSW'(i + 1);
    end
    send_act(vec, exp);
    bus.act_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.out_valid) lat = cyc - acc_cyc;
    end
    check("identity_latency", lat, 16);
    @(posedge clk);
    #1;
    wait_out(1);

    // Signed extremes; reload from RUN with nothing in flight passes DRAIN in one cycle
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = -8'sd128;
    load_weights(fw);
    check("drain_empty_wait", fw, 2);
    for (int i = 0; i < ROWS; i++) vec[i*AW +: AW] = 8'h80;
    for (int j = 0; j < COLS; j++) exp[j*PSW +: PSW] = PSW'(131072);
    send_act(vec, exp);
    bus.act_valid = 1'b0;
    wait_out(2);

    // Column bypass (ignored when the feature is compiled out)
    col_disable = 8'b0000_0100;
`ifdef STRAIT_COL_BYPASS_EN
    exp_mask = 8'b0000_0100;
`endif
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = 8'sd1;
    load_weights(fw);
    for (int i = 0; i < ROWS; i++) vec[i*AW +: AW] = 8'd1;
    for (int j = 0; j < COLS; j++) exp[j*PSW +: PSW] = exp_mask[j] ? PSW'(0) : PSW'(8);
    send_act(vec, exp);
    bus.act_valid = 1'b0;
    wait_out(3);
    col_disable = '0;
    exp_mask    = '0;

    // Streaming with random backpressure
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = WW'($urandom);
    load_weights(fw);
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < ROWS; i++) vec[i*AW +: AW] = AW'($urandom);
      send_act(vec, golden(vec));
    end
    bus.act_valid = 1'b0;
    wait_out(23);
    rand_ready = 1'b0;

    // Reload with 5 vectors in flight
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = WW'(i - j);
    load_weights(fw);
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < ROWS; i++) vec[i*AW +: AW] = AW'(n * 7 + i - 20);
      send_act(vec, golden(vec));
    end
    bus.act_valid = 1'b0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = WW'(3 * j - i);
    for (int j = 0; j < COLS; j++) bus.w_row[j*WW +: WW] = wm[ROWS-1][j];
    bus.w_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_act_ready", bus.act_ready, 0);
    check("drain_w_ready", bus.w_ready, 0);
    check("drain_busy", busy, 1);
    @(posedge clk);
    #1;
    load_weights(fw);
    check("reload_all_delivered", n_out, 28);
    for (int i = 0; i < ROWS; i++) vec[i*AW +: AW] = AW'(i * 5 - 9);
    send_act(vec, golden(vec));
    bus.act_valid = 1'b0;
    wait_out(29);

    // Reset with 10 vectors in flight
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < ROWS; i++) vec[i*AW +: AW] = AW'($urandom);
      send_act(vec, golden(vec));
    end
    bus.act_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    base = n_out;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_idle_w_ready", bus.w_ready, 1);
    check("post_rst_act_ready", bus.act_ready, 0);
    repeat (40) @(posedge clk);
    #1;
    check("no_stale_outputs", n_out, base);

    // Recovery after reset
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = (i == j) ? 8'sd1 : 8'sd0;
    load_weights(fw);
    exp = '0;
    for (int i = 0; i < ROWS; i++) begin
      vec[i*AW +: AW] = AW'(10 - i);
      exp[i*PSW +: PSW] = PSW'(10 - i);
    end
    send_act(vec, exp);
    bus.act_valid = 1'b0;
    wait_out(base + 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
